rfic_ctrl_out_monitor: RTL and testbench
========================================

Name: rfic_ctrl_out_monitor

Overview:
- Captures the asynchronous AD9361 CTRL_OUT status pins (8 bits per RFIC) into the fabric clock domain.
- Glitch-filters the captured pins and detects masked changes.
- Queues each change as a timestamped event in a small FIFO, drained by a valid/ready reader (AXI-lite register front end or DMA).
- Sits beside the EMIO GPIO path. It is the receive/observe counterpart of the processor-driven CTRL_IN/enable/txnrx outputs, and gives software precise timing of gain/calibration status transitions instead of polled GPIO reads.

Parameters:
- WIDTH, 8, number of CTRL_OUT bits monitored.
- TS_WIDTH, 24, free-running timestamp width in clocks.
- FIFO_DEPTH, 16, event FIFO entries; power of 2, ≥ 2.
- FILTER_CYCLES, 2, consecutive stable clocks required before a new pin vector is accepted; range 1..15.

Ports:
- clk  in  1  fabric clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- ctrl_out_in  in  WIDTH  raw CTRL_OUT pins, asynchronous to clk.
- enable  in  1  1 = events are queued; 0 = filtering continues, no pushes.
- mask  in  WIDTH  per-bit change enable; 1 = a change on that bit generates an event.
- irq_thresh  in  $clog2(FIFO_DEPTH)+1  FIFO occupancy at which irq asserts; 0 disables the occupancy term.
- ev_valid  out  1  head event available.
- ev_ready  in  1  reader accepts head event.
- ev_data  out  TS_WIDTH+WIDTH  {timestamp, filtered pin state}.
- ev_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- state_filt  out  WIDTH  current filtered pin state.
- overflow  out  1  sticky; set when an event is dropped.
- overflow_clr  in  1  single-cycle pulse clearing overflow and drop_cnt.
- drop_cnt  out  8  dropped-event count, saturates at 255.
- irq  out  1  level interrupt.

Behaviour:
- Reset (async assert, sync release): sync stages, state_filt, filter counter, timestamp, FIFO pointers, ev_count, overflow, drop_cnt all 0. ev_valid=0, ev_data=0, irq=0.
- Synchronizer: two-flop chain sync1 to sync2 on all bits, marked ASYNC_REG. No other logic touches ctrl_out_in.
- Filter: cand register plus stable counter.
  - If sync2 != cand: cand <= sync2, counter <= 1.
  - Else if counter < FILTER_CYCLES: counter increments.
  - When counter reaches FILTER_CYCLES and cand != state_filt: state_filt <= cand.
  - Pulses shorter than FILTER_CYCLES clocks at sync2 never reach state_filt.
- Timestamp: increments every clock. Wraps from 2^TS_WIDTH-1 to 0 with no flag.
- Event: when state_filt updates and ((new ^ old) & mask) != 0 and enable=1, push {ts, new}. ts is the timestamp value in the cycle state_filt updates. Unmasked-only changes update state_filt but push nothing.
- FIFO: first-word-fall-through; ev_data and ev_valid are registered.
  - Pop occurs when ev_valid & ev_ready.
  - Push and pop in the same cycle: both happen, ev_count unchanged.
  - Full with push and no pop: event dropped, overflow <= 1, drop_cnt += 1 (saturating).
  - Full with push and pop in the same cycle: push accepted, no drop.
  - ev_data holds stable while ev_valid=1 & ev_ready=0.
- Latency, FIFO empty: ev_valid rises exactly FILTER_CYCLES+3 clock edges after the edge at which sync1 first captures a stable new value (5 at default).
- overflow_clr: clears overflow and drop_cnt. If a drop occurs in the same cycle, the set wins (overflow=1, drop_cnt=1).
- irq = overflow | (irq_thresh != 0 & ev_count >= irq_thresh). Registered, one cycle behind its terms.
- enable deasserted mid-operation: queued events remain readable; no new pushes.
- mask and enable are sampled in the update cycle only.
- Async reset mid-operation discards all queued events. The first event after release reflects only changes detected after filter refill.

Test Plan:
- Single masked change: mask=0xFF, FILTER_CYCLES=2, ctrl_out_in 0x00 to 0x04 held → ev_valid rises 5 edges later; ev_data={ts, 0x04}; ts = cycle of state_filt update; ev_count=1, then 0 after handshake.
- Glitch reject: 1-clock pulse 0x01 on ctrl_out_in → no event, state_filt stays 0x00. A 3-clock pulse → two events, 0x01 then 0x00.
- Mask/enable: mask=0x0F, bit 7 toggles → state_filt follows, no event. enable=0 with bit 0 toggling → no event; ev_count unchanged.
- Overflow: 20 spaced changes, ev_ready=0, depth 16 → ev_count=16, overflow=1, drop_cnt=4, irq=1. Drain all 16 → timestamps strictly ordered; overflow stays 1 until overflow_clr.
- Full with simultaneous push/pop: FIFO full, ev_ready=1 in the push cycle → no drop; ev_count stays 16.
- Backpressure and reset: ev_ready toggling randomly → ev_data stable while stalled. resetn asserted with 7 queued → ev_valid=0, ev_count=0, timestamp=0 immediately (async).

Source files
------------

// File: rtl/rfic_ctrl_out_monitor.sv
// AD9361 CTRL_OUT observer: synchronizes and glitch-filters the status pins,
// then queues each masked change as a {timestamp, state} event in a FWFT FIFO.
module rfic_ctrl_out_monitor #(
    parameter int WIDTH         = 8,
    parameter int TS_WIDTH      = 24,
    parameter int FIFO_DEPTH    = 16,
    parameter int FILTER_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [WIDTH-1:0]              ctrl_out_in,
    input  logic                          enable,
    input  logic [WIDTH-1:0]              mask,
    input  logic [$clog2(FIFO_DEPTH):0]   irq_thresh,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [TS_WIDTH+WIDTH-1:0]     ev_data,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic [WIDTH-1:0]              state_filt,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic [7:0]                    drop_cnt,
    output logic                          irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = TS_WIDTH + WIDTH;
    localparam logic [3:0]    FILT  = 4'(FILTER_CYCLES);
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync1_q;
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync2_q;

    logic [WIDTH-1:0]    cand_q, cand_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]    filt_q, filt_d;
    logic                upd, ev_hit;
    logic [TS_WIDTH-1:0] ts_q;
    logic                pend_q;
    logic [DW-1:0]       pend_data_q;

    logic [DW-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d, remaining;
    logic                ev_valid_q, ev_valid_d;
    logic [DW-1:0]       ev_data_q, ev_data_d;
    logic                pop, full, push, drop;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic                irq_q, irq_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ctrl_out_in;
            sync2_q <= sync1_q;
        end
    end

    // A candidate is promoted once it has been seen FILTER_CYCLES clocks in a row.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = 4'd1;
        end else if (cnt_q < FILT) begin
            cnt_d = cnt_q + 4'd1;
        end
        upd    = (cnt_q >= FILT) && (cand_q != filt_q);
        ev_hit = upd && enable && (((cand_q ^ filt_q) & mask) != '0);
        if (upd) begin
            filt_d = cand_q;
        end
    end

    always_comb begin
        pop       = ev_valid_q & ev_ready;
        full      = (count_q == DEPTH);
        push      = pend_q & (~full | pop);
        drop      = pend_q & full & ~pop;
        count_d   = count_q + CW'(push) - CW'(pop);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        wr_ptr_d  = wr_ptr_q + AW'(push);
        remaining = count_q - CW'(pop);
        ev_valid_d = (count_d != '0);
        ev_data_d  = ev_data_q;
        // Head register refills from the RAM, or straight from the push when the FIFO drains.
        if (remaining == '0) begin
            if (push) begin
                ev_data_d = pend_data_q;
            end
        end else begin
            ev_data_d = mem[rd_ptr_d];
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (overflow_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (overflow_clr) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
        irq_d = overflow_q | ((irq_thresh != '0) && (count_q >= irq_thresh));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cand_q      <= '0;
            cnt_q       <= '0;
            filt_q      <= '0;
            ts_q        <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ev_valid_q  <= 1'b0;
            ev_data_q   <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            ts_q        <= ts_q + TS_WIDTH'(1);
            pend_q      <= ev_hit;
            // Stamp with the time of the first cycle showing the new filtered state.
            pend_data_q <= {ts_q + TS_WIDTH'(1), cand_q};
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ev_valid_q  <= ev_valid_d;
            ev_data_q   <= ev_data_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            irq_q       <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= pend_data_q;
        end
    end

    assign ev_valid   = ev_valid_q;
    assign ev_data    = ev_data_q;
    assign ev_count   = count_q;
    assign state_filt = filt_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_rfic_ctrl_out_monitor.sv
// Directed bench for rfic_ctrl_out_monitor: expected events go into a queue,
// a negedge monitor pops and compares on every handshake.
module tb_rfic_ctrl_out_monitor;
    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  ctrl_out_in;
    logic        enable;
    logic [7:0]  mask;
    logic [4:0]  irq_thresh;
    logic        ev_valid;
    logic        ev_ready;
    logic [31:0] ev_data;
    logic [4:0]  ev_count;
    logic [7:0]  state_filt;
    logic        overflow;
    logic        overflow_clr;
    logic [7:0]  drop_cnt;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int cyc;
    logic [31:0] exp_q[$];
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [7:0]  cur;

    rfic_ctrl_out_monitor dut (
        .clk         (clk),
        .resetn      (resetn),
        .ctrl_out_in (ctrl_out_in),
        .enable      (enable),
        .mask        (mask),
        .irq_thresh  (irq_thresh),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_data     (ev_data),
        .ev_count    (ev_count),
        .state_filt  (state_filt),
        .overflow    (overflow),
        .overflow_clr(overflow_clr),
        .drop_cnt    (drop_cnt),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Reference timestamp: number of clock edges seen since reset release.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (ev_data !== prev_data) begin
                    bad++;
                    $display("FAIL stall_hold: ev_data=%h required %h", ev_data, prev_data);
                end
            end
            if (ev_valid && ev_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: ev_data=%h required none", ev_data);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (ev_data !== e) begin
                        bad++;
                        $display("FAIL event: ev_data=%h required %h", ev_data, e);
                    end else begin
                        $display("event ok: ts=%0d state=%h", ev_data[31:8], ev_data[7:0]);
                    end
                end
            end
            prev_stall = ev_valid && !ev_ready;
            prev_data  = ev_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("check ok: %s = %h", name, act);
        end
    endtask

    // Drive a new pin vector; when an event is due it is stamped 5 edges later.
    task automatic drive(input logic [7:0] v, input bit expect_ev);
        ctrl_out_in = v;
        if (expect_ev) exp_q.push_back({24'(cyc + 5), v});
    endtask

    initial begin
        resetn = 1'b0; ctrl_out_in = 8'h00; enable = 1'b1; mask = 8'hFF;
        irq_thresh = 5'd0; ev_ready = 1'b0; overflow_clr = 1'b0;
        tick(3);
        check("rst_ev_valid", 32'(ev_valid), 32'd0);
        check("rst_ev_count", 32'(ev_count), 32'd0);
        check("rst_ev_data", ev_data, 32'd0);
        check("rst_state_filt", 32'(state_filt), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        resetn = 1'b1;
        tick(4);

        // single masked change and latency
        drive(8'h04, 1'b1);
        tick(5);
        check("lat_valid_early", 32'(ev_valid), 32'd0);
        check("lat_state_filt", 32'(state_filt), 32'h04);
        tick(1);
        check("lat_valid_on", 32'(ev_valid), 32'd1);
        check("lat_count1", 32'(ev_count), 32'd1);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        check("lat_count0", 32'(ev_count), 32'd0);

        // glitch reject, then a 3-clock pulse
        drive(8'h05, 1'b0);
        tick(1);
        drive(8'h04, 1'b0);
        tick(8);
        check("glitch_state", 32'(state_filt), 32'h04);
        check("glitch_count", 32'(ev_count), 32'd0);
        drive(8'h05, 1'b1);
        tick(3);
        drive(8'h04, 1'b1);
        ev_ready = 1'b1;
        tick(12);
        ev_ready = 1'b0;
        check("pulse3_count", 32'(ev_count), 32'd0);

        // mask and enable
        mask = 8'h0F;
        drive(8'h84, 1'b0);
        tick(8);
        check("mask_state", 32'(state_filt), 32'h84);
        check("mask_count", 32'(ev_count), 32'd0);
        mask = 8'hFF; enable = 1'b0;
        drive(8'h85, 1'b0);
        tick(8);
        check("enable_state", 32'(state_filt), 32'h85);
        check("enable_count", 32'(ev_count), 32'd0);
        enable = 1'b1;

        // overflow: 20 changes into a 16-deep FIFO
        irq_thresh = 5'd8;
        cur = 8'h85;
        for (int i = 0; i < 20; i++) begin
            cur = cur ^ 8'h02;
            drive(cur, i < 16);
            tick(6);
        end
        tick(4);
        check("ovf_count", 32'(ev_count), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd4);
        check("ovf_irq", 32'(irq), 32'd1);
        ev_ready = 1'b1;
        tick(20);
        ev_ready = 1'b0;
        check("drain_count", 32'(ev_count), 32'd0);
        check("drain_ovf_sticky", 32'(overflow), 32'd1);
        irq_thresh = 5'd0;
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
        tick(1);
        check("clr_irq", 32'(irq), 32'd0);

        // full FIFO with push and pop on the same edge
        for (int i = 0; i < 16; i++) begin
            cur = cur ^ 8'h10;
            drive(cur, 1'b1);
            tick(6);
        end
        tick(4);
        check("full_count", 32'(ev_count), 32'd16);
        cur = cur ^ 8'h20;
        drive(cur, 1'b1);
        tick(5);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        check("pushpop_count", 32'(ev_count), 32'd16);
        check("pushpop_drop", 32'(drop_cnt), 32'd0);
        check("pushpop_ovf", 32'(overflow), 32'd0);
        ev_ready = 1'b1;
        tick(20);
        ev_ready = 1'b0;
        check("pushpop_drain", 32'(ev_count), 32'd0);

        // random backpressure
        for (int i = 0; i < 6; i++) begin
            cur = cur ^ 8'h40;
            drive(cur, 1'b1);
            for (int k = 0; k < 6; k++) begin
                ev_ready = 1'($urandom_range(0, 1));
                tick(1);
            end
        end
        ev_ready = 1'b1;
        tick(20);
        ev_ready = 1'b0;
        check("bp_drain", 32'(ev_count), 32'd0);

        // async reset with events queued
        for (int i = 0; i < 7; i++) begin
            cur = cur ^ 8'h01;
            drive(cur, 1'b1);
            tick(6);
        end
        tick(4);
        check("pre_rst_count", 32'(ev_count), 32'd7);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_ev_valid", 32'(ev_valid), 32'd0);
        check("arst_ev_count", 32'(ev_count), 32'd0);
        check("arst_ev_data", ev_data, 32'd0);
        check("arst_state", 32'(state_filt), 32'd0);
        exp_q.delete();
        tick(2);
        resetn = 1'b1;
        drive(cur, 1'b1);
        ev_ready = 1'b1;
        tick(12);
        ev_ready = 1'b0;
        check("post_rst_state", 32'(state_filt), 32'(cur));
        check("post_rst_count", 32'(ev_count), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
